// File: rtl/uart_pkg.sv
// Register map, status bit layout and serial FSM encoding
// shared by the dual-FIFO APB UART.
package uart_pkg;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_TXDATA  = 2'd1;
    localparam logic [1:0] REG_RXDATA  = 2'd2;
    localparam logic [1:0] REG_BAUDDIV = 2'd3;

    localparam int ST_TX_EMPTY   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_TX_BUSY    = 4;
    localparam int ST_RX_OVERRUN = 5;
    localparam int ST_FRAME_ERR  = 6;
    localparam int ST_W          = 7;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags.
// A pop on a full FIFO frees the slot for a same-cycle push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_n;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_n = count;
        case ({do_push, do_pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/apb_uart_dual_fifo.sv
// APB3 UART with TX/RX FIFOs, programmable divisor and
// sticky overrun/framing flags; every access takes one wait state.
module apb_uart_dual_fifo #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8,
    parameter int OVS        = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        tx,
    input  logic        rx
);

    import uart_pkg::*;

    localparam int          TW      = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [15:0] DIV_RST = 16'(CLK_HZ / (BAUD * OVS));
    localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);

    logic        access;
    logic        wr_en;
    logic        rd_en;
    logic [1:0]  reg_sel;
    logic        st_wr;
    logic        div_wr;
    logic [31:0] rdata;
    logic [ST_W-1:0] status;

    logic [15:0] baud_div;
    logic [15:0] tick_cnt;
    logic        tick;

    logic        tx_push;
    logic        tx_pop;
    logic [7:0]  tx_dout;
    logic        tx_full;
    logic        tx_empty;
    logic        tx_busy;
    uart_state_e tx_state;
    uart_state_e tx_next;
    logic [TW-1:0] tx_tcnt;
    logic [2:0]  tx_bcnt;
    logic [7:0]  tx_shift;
    logic        tx_bit_end;

    logic        rx_meta;
    logic        rx_s;
    logic        rx_push;
    logic        rx_pop;
    logic [7:0]  rx_dout;
    logic        rx_full;
    logic        rx_empty;
    uart_state_e rx_state;
    uart_state_e rx_next;
    logic [TW-1:0] rx_tcnt;
    logic [2:0]  rx_bcnt;
    logic [7:0]  rx_shift;
    logic        rx_half;
    logic        rx_bit_end;
    logic        rx_stop_end;

    logic        rx_overrun;
    logic        frame_err;
    logic        ovr_set;
    logic        ferr_set;
    logic        ovr_clr;
    logic        ferr_clr;
    logic        unused_ok;

    assign unused_ok = ^{PWDATA[31:16], PADDR[1:0]};

    // APB decode; side effects fire only in the wait-state cycle
    assign access  = PSEL & PENABLE & ~PREADY;
    assign wr_en   = access & PWRITE;
    assign rd_en   = access & ~PWRITE;
    assign reg_sel = PADDR[3:2];
    assign st_wr   = wr_en & (reg_sel == REG_STATUS);
    assign div_wr  = wr_en & (reg_sel == REG_BAUDDIV);
    assign tx_push = wr_en & (reg_sel == REG_TXDATA);
    assign rx_pop  = rd_en & (reg_sel == REG_RXDATA);
    assign ovr_clr  = st_wr & PWDATA[ST_RX_OVERRUN];
    assign ferr_clr = st_wr & PWDATA[ST_FRAME_ERR];

    always_comb begin
        status = '0;
        status[ST_TX_EMPTY]   = tx_empty;
        status[ST_TX_FULL]    = tx_full;
        status[ST_RX_EMPTY]   = rx_empty;
        status[ST_RX_FULL]    = rx_full;
        status[ST_TX_BUSY]    = tx_busy;
        status[ST_RX_OVERRUN] = rx_overrun;
        status[ST_FRAME_ERR]  = frame_err;
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            reg_sel == REG_STATUS:  rdata = {{(32-ST_W){1'b0}}, status};
            reg_sel == REG_TXDATA:  rdata = '0;
            reg_sel == REG_RXDATA:  rdata = rx_empty ? '0 : {24'h0, rx_dout};
            reg_sel == REG_BAUDDIV: rdata = {16'h0, baud_div};
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PREADY <= 1'b0;
            PRDATA <= '0;
        end else begin
            PREADY <= access;
            PRDATA <= rd_en ? rdata : '0;
        end
    end

    // Sticky flags: a same-cycle set beats the W1C
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_overrun <= ovr_set | (rx_overrun & ~ovr_clr);
            frame_err  <= ferr_set | (frame_err & ~ferr_clr);
        end
    end

    assign tick = (tick_cnt >= baud_div - 16'd1);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            baud_div <= DIV_RST;
            tick_cnt <= '0;
        end else begin
            if (div_wr)
                baud_div <= clamp_div(PWDATA[15:0]);
            if (div_wr || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 16'd1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (tx_push),
        .din   (PWDATA[7:0]),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (rx_push),
        .din   (rx_shift),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign tx_bit_end = tick & (tx_tcnt == T_LAST);
    assign tx_busy    = (tx_state != IDLE);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            tx_state <= IDLE;
        else
            tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            IDLE:  if (!tx_empty) tx_next = START;
            START: if (tx_bit_end) tx_next = DATA;
            DATA:  if (tx_bit_end && tx_bcnt == 3'd7) tx_next = STOP;
            STOP:  if (tx_bit_end) tx_next = IDLE;
            default: tx_next = IDLE;
        endcase
    end

    always_comb begin
        tx     = 1'b1;
        tx_pop = 1'b0;
        case (tx_state)
            IDLE:  tx_pop = ~tx_empty;
            START: tx     = 1'b0;
            DATA:  tx     = tx_shift[0];
            STOP:  tx     = 1'b1;
            default: tx   = 1'b1;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_shift <= '0;
        end else if (tx_state == IDLE) begin
            tx_tcnt <= '0;
            tx_bcnt <= '0;
            if (tx_pop)
                tx_shift <= tx_dout;
        end else if (tick) begin
            tx_tcnt <= tx_bit_end ? '0 : tx_tcnt + TW'(1);
            if (tx_bit_end && tx_state == DATA) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bcnt  <= tx_bcnt + 3'd1;
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign rx_half     = tick & (rx_tcnt == T_HALF);
    assign rx_bit_end  = tick & (rx_tcnt == T_LAST);
    assign rx_stop_end = (rx_state == STOP) & rx_bit_end;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            rx_state <= IDLE;
        else
            rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (!rx_s) rx_next = START;
            START: if (rx_half) rx_next = rx_s ? IDLE : DATA;
            DATA:  if (rx_bit_end && rx_bcnt == 3'd7) rx_next = STOP;
            STOP:  if (rx_bit_end) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    // A pop in the same cycle makes room, so that push is no overrun
    always_comb begin
        rx_push  = rx_stop_end & rx_s;
        ovr_set  = rx_push & rx_full & ~rx_pop;
        ferr_set = rx_stop_end & ~rx_s;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_shift <= '0;
        end else if (rx_state == IDLE) begin
            rx_tcnt <= '0;
            rx_bcnt <= '0;
        end else if (tick) begin
            if (rx_state == START)
                rx_tcnt <= rx_half ? '0 : rx_tcnt + TW'(1);
            else
                rx_tcnt <= rx_bit_end ? '0 : rx_tcnt + TW'(1);
            if (rx_bit_end && rx_state == DATA) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                rx_bcnt  <= rx_bcnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_uart_dual_fifo.sv
// Directed bench for apb_uart_dual_fifo: APB handshake,
// TX framing/overflow, RX overrun/framing/glitch, reset, clamp.
module tb_apb_uart_dual_fifo;

    localparam int EXP_DIV = 100_000_000 / (9600 * 16);
    localparam int BIT     = 64;
    localparam logic [3:0] A_STATUS = 4'h0;
    localparam logic [3:0] A_TX     = 4'h4;
    localparam logic [3:0] A_RX     = 4'h8;
    localparam logic [3:0] A_DIV    = 4'hC;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        tx;
    logic        rx;

    int checks = 0;
    int errors = 0;

    logic       mon_en = 1'b0;
    logic [9:0] mon_f;
    logic [9:0] txq[$];

    apb_uart_dual_fifo dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .tx      (tx),
        .rx      (rx)
    );

    always #5 PCLK = ~PCLK;

    // Frame capture on tx: mid-bit sampling at 64 cycles/bit
    always begin
        @(negedge tx);
        if (mon_en) begin
            repeat (BIT / 2) @(posedge PCLK);
            for (int i = 0; i < 10; i++) begin
                mon_f[i] = tx;
                if (i < 9)
                    repeat (BIT) @(posedge PCLK);
            end
            txq.push_back(mon_f);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic w, input logic [3:0] a,
                       input logic [31:0] d, output logic [31:0] r);
        int n;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = w;
        PADDR   = a;
        PWDATA  = d;
        step(1);
        PENABLE = 1'b1;
        chk("pready_low_in_wait", {31'h0, PREADY}, 32'h0);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!PREADY && n < 8);
        chk("one_wait_state", n, 1);
        r = PRDATA;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        step(1);
        chk("pready_drops", {31'h0, PREADY}, 32'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] r;
        apb(1'b1, a, d, r);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a,
                          input logic [31:0] exp);
        logic [31:0] r;
        apb(1'b0, a, 32'h0, r);
        chk(tag, r, exp);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit,
                           input int stop_len);
        rx = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(BIT);
        end
        rx = stop_bit;
        step(stop_len);
        rx = 1'b1;
        step(BIT);
    endtask

    initial begin
        int n;
        logic [9:0] f;
        logic [7:0] burst [3];
        burst[0] = 8'hA5;
        burst[1] = 8'h3C;
        burst[2] = 8'hFF;

        PRESET  = 1'b1;
        PADDR   = '0;
        PWDATA  = '0;
        PWRITE  = 1'b0;
        PENABLE = 1'b0;
        PSEL    = 1'b0;
        rx      = 1'b1;
        step(3);
        chk("rst_tx", {31'h0, tx}, 32'h1);
        chk("rst_pready", {31'h0, PREADY}, 32'h0);
        chk("rst_prdata", PRDATA, 32'h0);
        PRESET = 1'b0;
        step(2);
        rd_chk("rst_status", A_STATUS, 32'h05);
        rd_chk("rst_bauddiv", A_DIV, EXP_DIV);
        rd_chk("rx_empty_read", A_RX, 32'h0);

        // TX burst at 4 clocks/tick
        wr(A_DIV, 32'd4);
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++)
            wr(A_TX, {24'h0, burst[i]});
        rd_chk("burst_status", A_STATUS, 32'h14);
        n = 0;
        while (txq.size() < 3 && n < 3000) begin
            step(1);
            n++;
        end
        chk("burst_frames", txq.size(), 3);
        for (int i = 0; i < 3; i++) begin
            f = (txq.size() > 0) ? txq.pop_front() : 10'h3FF;
            chk("burst_frame", {22'h0, f}, {22'h0, 1'b1, burst[i], 1'b0});
        end
        step(BIT);
        rd_chk("burst_done_status", A_STATUS, 32'h05);

        // TX overflow: 10 rapid writes, 10th must be dropped
        for (int i = 0; i < 10; i++)
            wr(A_TX, i);
        rd_chk("tx_full_status", A_STATUS, 32'h16);
        n = 0;
        while (txq.size() < 9 && n < 7000) begin
            step(1);
            n++;
        end
        chk("ovf_frames", txq.size(), 9);
        for (int i = 0; i < 9; i++) begin
            f = (txq.size() > 0) ? txq.pop_front() : 10'h3FF;
            chk("ovf_frame", {22'h0, f}, {22'h0, 1'b1, 8'(i), 1'b0});
        end
        step(12 * BIT);
        chk("ovf_no_extra", txq.size(), 0);
        rd_chk("ovf_done_status", A_STATUS, 32'h05);
        mon_en = 1'b0;

        // RX: 9 frames into an 8-deep FIFO
        for (int i = 0; i < 9; i++)
            send_rx(8'(8'h11 + i), 1'b1, BIT);
        rd_chk("rx_full_ovr", A_STATUS, 32'h29);
        for (int i = 0; i < 8; i++)
            rd_chk("rx_data", A_RX, 32'h11 + i);
        rd_chk("rx_data_empty", A_RX, 32'h0);
        rd_chk("rx_drained", A_STATUS, 32'h25);
        wr(A_STATUS, 32'h20);
        rd_chk("ovr_cleared", A_STATUS, 32'h05);

        // Framing error: stop bit low, released early
        send_rx(8'h5A, 1'b0, 40);
        rd_chk("frame_err", A_STATUS, 32'h45);
        rd_chk("frame_no_push", A_RX, 32'h0);
        wr(A_STATUS, 32'h40);
        rd_chk("ferr_cleared", A_STATUS, 32'h05);

        // Short low pulse must be rejected
        rx = 1'b0;
        step(20);
        rx = 1'b1;
        step(100);
        rd_chk("glitch_reject", A_STATUS, 32'h05);

        // Reset in the middle of a frame
        wr(A_TX, 32'h55);
        wr(A_TX, 32'h77);
        step(100);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            step(1);
            n++;
        end
        chk("tx_low_midframe", {31'h0, tx}, 32'h0);
        PRESET = 1'b1;
        #1;
        chk("tx_high_on_reset", {31'h0, tx}, 32'h1);
        step(2);
        PRESET = 1'b0;
        step(2);
        chk("tx_idle_after_reset", {31'h0, tx}, 32'h1);
        rd_chk("reset_status", A_STATUS, 32'h05);
        rd_chk("reset_bauddiv", A_DIV, EXP_DIV);

        // Divisor clamp
        wr(A_DIV, 32'd0);
        rd_chk("div_clamp0", A_DIV, 32'd2);
        wr(A_DIV, 32'd1);
        rd_chk("div_clamp1", A_DIV, 32'd2);
        wr(A_DIV, 32'd3);
        rd_chk("div_three", A_DIV, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
